quadrilatero_mperm_unit: RTL and testbench

- Successor to the zero-only permutation unit; generalises it to three row-wise operations on a destination matrix register: ZERO, FILL with a replicated scalar, and MOVE (register-to-register copy).
- Queues instructions in an issue FIFO and streams N_ROWS rows into the register-file write port.
- For MOVE, reads source rows through a dedicated register-file read port.
- Sits beside the load/store and systolic units in the quadrilatero matrix engine.

---
 rtl/quadrilatero_mperm_unit_if.sv | 49 ++++
 rtl/quadrilatero_mperm_unit.sv | 182 ++++++++++++++++++
 tb/tb_quadrilatero_mperm_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quadrilatero_mperm_unit_if.sv
// Issue, register-file read/write and completion signals of the quadrilatero permutation unit.
// The unit connects through the slave modport; the issuing/RF side uses master.
interface quadrilatero_mperm_unit_if #(
    parameter int unsigned RLEN       = 128,
    parameter int unsigned N_REGS     = 8,
    parameter int unsigned N_ROWS     = 4,
    parameter int unsigned X_ID_WIDTH = 4
);
    localparam int unsigned RW  = $clog2(N_REGS);
    localparam int unsigned RRW = $clog2(N_ROWS);

    logic                  start_i;
    logic [1:0]            op_i;
    logic [RW-1:0]         operand_reg_i;
    logic [RW-1:0]         src_reg_i;
    logic [31:0]           scalar_i;
    logic [1:0]            sew_i;
    logic [X_ID_WIDTH-1:0] instr_id_i;
    logic                  busy_o;
    logic [X_ID_WIDTH-1:0] id_o;
    logic [RW-1:0]         raddr_o;
    logic [RRW-1:0]        rrowaddr_o;
    logic                  re_o;
    logic                  rready_i;
    logic [RLEN-1:0]       rdata_i;
    logic [RW-1:0]         waddr_o;
    logic [RRW-1:0]        wrowaddr_o;
    logic [RLEN-1:0]       wdata_o;
    logic                  we_o;
    logic                  wlast_o;
    logic                  wready_i;
    logic                  finished_o;
    logic                  finished_ack_i;
    logic [X_ID_WIDTH-1:0] finished_instr_id_o;

    modport slave (
        input  start_i, op_i, operand_reg_i, src_reg_i, scalar_i, sew_i, instr_id_i,
               rready_i, rdata_i, wready_i, finished_ack_i,
        output busy_o, id_o, raddr_o, rrowaddr_o, re_o, waddr_o, wrowaddr_o, wdata_o,
               we_o, wlast_o, finished_o, finished_instr_id_o
    );

    modport master (
        output start_i, op_i, operand_reg_i, src_reg_i, scalar_i, sew_i, instr_id_i,
               rready_i, rdata_i, wready_i, finished_ack_i,
        input  busy_o, id_o, raddr_o, rrowaddr_o, re_o, waddr_o, wrowaddr_o, wdata_o,
               we_o, wlast_o, finished_o, finished_instr_id_o
    );
endinterface

// File: rtl/quadrilatero_mperm_unit.sv
// Row-wise ZERO / FILL / MOVE unit for a destination matrix register, fed by an issue FIFO.
// MOVE (read port, row buffer) exists only when QUADRILATERO_PERM_MOVE_EN is defined.
module quadrilatero_mperm_unit #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned RLEN       = 128,
    parameter int unsigned N_REGS     = 8,
    parameter int unsigned N_ROWS     = 4,
    parameter int unsigned X_ID_WIDTH = 4
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    quadrilatero_mperm_unit_if.slave  mperm
);
    localparam int unsigned RW  = $clog2(N_REGS);
    localparam int unsigned RRW = $clog2(N_ROWS);
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned UW  = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {OP_ZERO = 2'd0, OP_FILL = 2'd1, OP_MOVE = 2'd2, OP_RSVD = 2'd3} op_e;
    typedef enum logic [1:0] {IDLE, WRITE, READ, RWAIT} state_e;

    typedef struct packed {
        op_e                   op;
        logic [RW-1:0]         dst;
        logic [RW-1:0]         src;
        logic [31:0]           scalar;
        logic [1:0]            sew;
        logic [X_ID_WIDTH-1:0] id;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          in_entry, head, cur;
    logic [PW-1:0]   wptr, rptr;
    logic [UW-1:0]   usage;
    logic            full, empty, push, pop;
    state_e          state;
    logic [RRW-1:0]  cnt;
    logic            last_row, we, wr_fire, wlast;
    logic            fin_q;
    logic [X_ID_WIDTH-1:0] fin_id_q;
    logic            head_move, cur_move;
    logic [RLEN-1:0] wdata;

    always_comb begin
        in_entry        = '0;
        in_entry.op     = op_e'(mperm.op_i);
        in_entry.dst    = mperm.operand_reg_i;
        in_entry.src    = mperm.src_reg_i;
        in_entry.scalar = mperm.scalar_i;
        in_entry.sew    = mperm.sew_i;
        in_entry.id     = mperm.instr_id_i;
    end

    assign head  = mem[rptr];
    assign full  = (usage == UW'(DEPTH));
    assign empty = (usage == '0);
    assign push  = mperm.start_i & ~full;

    // A pending completion that nobody has acknowledged blocks the next last-row write.
    assign last_row = (cnt == RRW'(N_ROWS - 1));
    assign we       = (state == WRITE) & ~(last_row & fin_q & ~mperm.finished_ack_i);
    assign wr_fire  = we & mperm.wready_i;
    assign wlast    = wr_fire & last_row;
    assign pop      = ~empty & ((state == IDLE) | wlast);

`ifdef QUADRILATERO_PERM_MOVE_EN
    logic [RLEN-1:0] row_buf;
    assign head_move = (head.op == OP_MOVE);
    assign cur_move  = (cur.op == OP_MOVE);
`else
    logic unused_move;
    assign head_move   = 1'b0;
    assign cur_move    = 1'b0;
    assign unused_move = ^{mperm.rready_i, mperm.rdata_i, cur.src};
`endif

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= in_entry;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            usage <= '0;
        end else begin
            if (push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            if (pop)  rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            usage <= usage + UW'(push) - UW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            cur      <= '0;
            cnt      <= '0;
            fin_q    <= 1'b0;
            fin_id_q <= '0;
        end else begin
            if (wlast) begin
                fin_q    <= 1'b1;
                fin_id_q <= cur.id;
            end else if (mperm.finished_ack_i) begin
                fin_q <= 1'b0;
            end
            unique case (state)
                IDLE: if (pop) begin
                    cur   <= head;
                    cnt   <= '0;
                    state <= head_move ? READ : WRITE;
                end
`ifdef QUADRILATERO_PERM_MOVE_EN
                READ:  if (mperm.rready_i) state <= RWAIT;
                RWAIT: state <= WRITE;
`endif
                WRITE: if (wr_fire) begin
                    if (!last_row) begin
                        cnt   <= cnt + 1'b1;
                        state <= cur_move ? READ : WRITE;
                    end else if (pop) begin
                        cur   <= head;
                        cnt   <= '0;
                        state <= head_move ? READ : WRITE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef QUADRILATERO_PERM_MOVE_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)             row_buf <= '0;
        else if (state == RWAIT) row_buf <= mperm.rdata_i;
    end
    assign mperm.re_o       = (state == READ);
    assign mperm.raddr_o    = (state == READ) ? cur.src : '0;
    assign mperm.rrowaddr_o = (state == READ) ? cnt : '0;
`else
    assign mperm.re_o       = 1'b0;
    assign mperm.raddr_o    = '0;
    assign mperm.rrowaddr_o = '0;
`endif

    always_comb begin
        wdata = '0;
        if (state == WRITE) begin
            unique case (cur.op)
                OP_FILL: begin
                    unique case (cur.sew)
                        2'd0:    wdata = {(RLEN / 8){cur.scalar[7:0]}};
                        2'd1:    wdata = {(RLEN / 16){cur.scalar[15:0]}};
                        default: wdata = {(RLEN / 32){cur.scalar}};
                    endcase
                end
`ifdef QUADRILATERO_PERM_MOVE_EN
                OP_MOVE: wdata = row_buf;
`endif
                default: wdata = '0;
            endcase
        end
    end

    assign mperm.busy_o              = full | (usage == UW'(DEPTH - 1));
    assign mperm.id_o                = cur.id;
    assign mperm.we_o                = we;
    assign mperm.wlast_o             = wlast;
    assign mperm.waddr_o             = (state == WRITE) ? cur.dst : '0;
    assign mperm.wrowaddr_o          = (state == WRITE) ? cnt : '0;
    assign mperm.wdata_o             = wdata;
    assign mperm.finished_o          = fin_q;
    assign mperm.finished_instr_id_o = fin_id_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) assert (!(mperm.start_i && full)) else $error("start_i while issue FIFO full");
    end
`endif
endmodule

// File: tb/tb_quadrilatero_mperm_unit.sv
// Scoreboard bench for quadrilatero_mperm_unit: expected row writes and completions are queued at issue.
module tb_quadrilatero_mperm_unit;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned RLEN   = 128;
    localparam int unsigned N_REGS = 8;
    localparam int unsigned N_ROWS = 4;
    localparam int unsigned IDW    = 4;
    localparam int unsigned RW     = $clog2(N_REGS);
    localparam int unsigned RRW    = $clog2(N_ROWS);
`ifdef QUADRILATERO_PERM_MOVE_EN
    localparam bit MOVE_EN = 1'b1;
`else
    localparam bit MOVE_EN = 1'b0;
`endif

    typedef struct {
        logic [RW-1:0]   reg_a;
        logic [RRW-1:0]  row;
        logic [RLEN-1:0] data;
        logic            last;
    } wr_t;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    quadrilatero_mperm_unit_if #(.RLEN(RLEN), .N_REGS(N_REGS), .N_ROWS(N_ROWS), .X_ID_WIDTH(IDW)) bus ();

    quadrilatero_mperm_unit #(.DEPTH(DEPTH), .RLEN(RLEN), .N_REGS(N_REGS), .N_ROWS(N_ROWS), .X_ID_WIDTH(IDW)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .mperm (bus.slave)
    );

    int vectors, miscompares;
    wr_t wq[$];
    logic [IDW-1:0] fq[$];
    logic [RLEN-1:0] rf [N_REGS][N_ROWS];
    bit hold_ack, wready_rand;
    int rd_stall, rd_grants;
    logic rd_req;
    logic [RW-1:0] rd_reg;
    logic [RRW-1:0] rd_row;

    function automatic logic [RLEN-1:0] fill_row(input logic [31:0] s, input logic [1:0] sew);
        logic [RLEN-1:0] r;
        int unsigned eb;
        eb = (sew == 2'd0) ? 1 : (sew == 2'd1) ? 2 : 4;
        for (int unsigned b = 0; b < RLEN / 8; b++) r[b*8 +: 8] = s[(b % eb)*8 +: 8];
        return r;
    endfunction

    // Monitor: write scoreboard, RF model update, read-port sanity, read-grant sampling.
    always @(negedge clk_i) begin
        rd_req = rst_ni & bus.re_o & bus.rready_i;
        rd_reg = bus.raddr_o;
        rd_row = bus.rrowaddr_o;
        if (rst_ni) begin
            if (rd_req) rd_grants++;
            if (bus.re_o || bus.we_o) begin
                vectors++;
                if ((bus.re_o && bus.we_o) || (!MOVE_EN && bus.re_o)) begin
                    miscompares++;
                    $display("FAIL port_usage: got re_o=%b we_o=%b, want at most one (re_o only with MOVE)", bus.re_o, bus.we_o);
                end
            end
            if (bus.we_o && bus.wready_i) begin
                wr_t e;
                vectors++;
                if (wq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: got reg=%0d row=%0d data=%h, want no write", bus.waddr_o, bus.wrowaddr_o, bus.wdata_o);
                end else begin
                    e = wq.pop_front();
                    if ({bus.waddr_o, bus.wrowaddr_o, bus.wdata_o, bus.wlast_o} !== {e.reg_a, e.row, e.data, e.last}) begin
                        miscompares++;
                        $display("FAIL row_write: got reg=%0d row=%0d data=%h last=%b, want reg=%0d row=%0d data=%h last=%b",
                                 bus.waddr_o, bus.wrowaddr_o, bus.wdata_o, bus.wlast_o, e.reg_a, e.row, e.data, e.last);
                    end
                end
                rf[bus.waddr_o][bus.wrowaddr_o] = bus.wdata_o;
            end else if (bus.wlast_o) begin
                vectors++;
                miscompares++;
                $display("FAIL wlast_spurious: got wlast_o=1, want 0 without accepted write");
            end
        end
    end

    // Responder: port handshakes, RF read data, completion acknowledge and id check.
    always @(posedge clk_i) begin
        #1;
        bus.wready_i = wready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rd_stall > 0 && bus.re_o) begin
            bus.rready_i = 1'b0;
            rd_stall--;
        end else begin
            bus.rready_i = 1'b1;
        end
        bus.rdata_i = rd_req ? rf[rd_reg][rd_row] : {(RLEN / 32){32'hDEAD_BEEF}};
        if (rst_ni && !hold_ack && bus.finished_o) begin
            bus.finished_ack_i = 1'b1;
            vectors++;
            if (fq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_finish: got id=%0d, want no completion", bus.finished_instr_id_o);
            end else begin
                logic [IDW-1:0] want;
                want = fq.pop_front();
                if (bus.finished_instr_id_o !== want) begin
                    miscompares++;
                    $display("FAIL finished_id: got %0d, want %0d", bus.finished_instr_id_o, want);
                end
            end
        end else begin
            bus.finished_ack_i = 1'b0;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [RW-1:0] dst, input logic [RW-1:0] src,
                         input logic [31:0] scalar, input logic [1:0] sew, input logic [IDW-1:0] id);
        wr_t e;
        bus.op_i = op; bus.operand_reg_i = dst; bus.src_reg_i = src;
        bus.scalar_i = scalar; bus.sew_i = sew; bus.instr_id_i = id;
        bus.start_i = 1'b1;
        for (int unsigned r = 0; r < N_ROWS; r++) begin
            e.reg_a = dst;
            e.row   = RRW'(r);
            e.last  = (r == N_ROWS - 1);
            if (op == 2'd1)                 e.data = fill_row(scalar, sew);
            else if (op == 2'd2 && MOVE_EN) e.data = rf[src][r];
            else                            e.data = '0;
            wq.push_back(e);
        end
        fq.push_back(id);
        @(negedge clk_i);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (wq.size() == 0 && fq.size() == 0 && !bus.finished_o && !bus.we_o && !bus.busy_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        vectors++;
        if ({bus.we_o, bus.wlast_o, bus.waddr_o, bus.wrowaddr_o, bus.wdata_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_write_port: got we=%b wlast=%b waddr=%0d wrow=%0d wdata=%h, want all 0",
                     bus.we_o, bus.wlast_o, bus.waddr_o, bus.wrowaddr_o, bus.wdata_o);
        end
        vectors++;
        if ({bus.re_o, bus.raddr_o, bus.rrowaddr_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_read_port: got re=%b raddr=%0d rrow=%0d, want all 0", bus.re_o, bus.raddr_o, bus.rrowaddr_o);
        end
        vectors++;
        if ({bus.busy_o, bus.id_o, bus.finished_o, bus.finished_instr_id_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_status: got busy=%b id=%0d fin=%b fin_id=%0d, want all 0",
                     bus.busy_o, bus.id_o, bus.finished_o, bus.finished_instr_id_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_zero();
        bit ok;
        issue(2'd0, 3'd3, 3'd0, 32'hFFFF_FFFF, 2'd0, 4'd1);
        wait_drain(ok);
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL zero_drain: got timeout, want drained"); end
        vectors++;
        if ({bus.id_o, bus.wdata_o} !== {4'd1, {RLEN{1'b0}}}) begin
            miscompares++;
            $display("FAIL idle_outputs: got id=%0d wdata=%h, want id=1 wdata=0", bus.id_o, bus.wdata_o);
        end
    endtask

    task automatic test_fill();
        logic [1:0]  ops [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3};
        logic [31:0] scl [5] = '{32'h5A3C_12A5, 32'hBEEF_1234, 32'hDEAD_BEEF, 32'h0123_4567, 32'hFFFF_FFFF};
        logic [1:0]  sews[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        logic [RW-1:0] dsts[5] = '{3'd0, 3'd1, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 5; i++) begin
            bit ok;
            issue(ops[i], dsts[i], 3'd0, scl[i], sews[i], IDW'(2 + i));
            wait_drain(ok);
            vectors++;
            if (ok !== 1'b1) begin miscompares++; $display("FAIL fill_drain_%0d: got timeout, want drained", i); end
        end
    endtask

    task automatic test_fill_wready_random();
        bit ok;
        wready_rand = 1'b1;
        issue(2'd1, 3'd4, 3'd0, 32'h0000_CAFE, 2'd1, 4'd7);
        issue(2'd0, 3'd4, 3'd0, 32'h0, 2'd0, 4'd8);
        wait_drain(ok);
        wready_rand = 1'b0;
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL wready_random_drain: got timeout, want drained"); end
    endtask

    task automatic test_move();
        bit ok;
        rd_grants = 0;
        rd_stall  = 2;
        issue(2'd2, 3'd2, 3'd1, 32'hFFFF_FFFF, 2'd0, 4'd9);
        wait_drain(ok);
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL move_drain: got timeout, want drained"); end
        vectors++;
        if (rd_grants !== (MOVE_EN ? N_ROWS : 0)) begin
            miscompares++;
            $display("FAIL move_reads: got %0d, want %0d", rd_grants, MOVE_EN ? N_ROWS : 0);
        end
        issue(2'd2, 3'd6, 3'd6, 32'h0, 2'd0, 4'd10);
        wait_drain(ok);
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL move_same_reg_drain: got timeout, want drained"); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        vectors++;
        if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_pre: got %b, want 0", bus.busy_o); end
        issue(2'd1, 3'd0, 3'd0, 32'h0000_0011, 2'd0, 4'd11);
        vectors++;
        if (bus.busy_o !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_push1: got %b, want 1", bus.busy_o); end
        issue(2'd1, 3'd1, 3'd0, 32'h0000_2222, 2'd1, 4'd12);
        issue(2'd1, 3'd2, 3'd0, 32'h3333_3333, 2'd2, 4'd13);
        // cycle 3 onward: writes continue through cycle 13, busy drops once the third entry is popped
        for (int cyc = 3; cyc < 16; cyc++) begin
            vectors++;
            if ({bus.we_o, bus.busy_o} !== {1'(cyc <= 13), 1'(cyc <= 9)}) begin
                miscompares++;
                $display("FAIL b2b_cycle_%0d: got we=%b busy=%b, want we=%b busy=%b",
                         cyc, bus.we_o, bus.busy_o, cyc <= 13, cyc <= 9);
            end
            @(negedge clk_i);
        end
        wait_drain(ok);
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL b2b_drain: got timeout, want drained"); end
    endtask

    task automatic test_finish_stall();
        bit ok;
        hold_ack = 1'b1;
        issue(2'd0, 3'd4, 3'd0, 32'h0, 2'd0, 4'd12);
        issue(2'd1, 3'd5, 3'd0, 32'h0000_0077, 2'd0, 4'd13);
        repeat (10) @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({bus.we_o, bus.finished_o, bus.finished_instr_id_o} !== {1'b0, 1'b1, 4'd12}) begin
                miscompares++;
                $display("FAIL stall_cycle_%0d: got we=%b fin=%b fin_id=%0d, want we=0 fin=1 fin_id=12",
                         i, bus.we_o, bus.finished_o, bus.finished_instr_id_o);
            end
            @(negedge clk_i);
        end
        hold_ack = 1'b0;
        @(negedge clk_i);
        vectors++;
        if ({bus.we_o, bus.wlast_o, bus.finished_ack_i} !== 3'b111) begin
            miscompares++;
            $display("FAIL stall_release: got we=%b wlast=%b ack=%b, want 1 1 1", bus.we_o, bus.wlast_o, bus.finished_ack_i);
        end
        @(negedge clk_i);
        vectors++;
        if ({bus.finished_o, bus.finished_instr_id_o} !== {1'b1, 4'd13}) begin
            miscompares++;
            $display("FAIL stall_new_id: got fin=%b fin_id=%0d, want fin=1 fin_id=13", bus.finished_o, bus.finished_instr_id_o);
        end
        wait_drain(ok);
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL stall_drain: got timeout, want drained"); end
    endtask

    task automatic test_reset_mid_move();
        bit ok, found;
        found = 1'b0;
        issue(2'd2, 3'd2, 3'd1, 32'h0, 2'd0, 4'd14);
        for (int i = 0; i < 100 && !found; i++) begin
            if (bus.we_o && bus.wrowaddr_o == 2'd2) found = 1'b1;
            else @(negedge clk_i);
        end
        vectors++;
        if (found !== 1'b1) begin miscompares++; $display("FAIL mid_move_row2: got timeout, want row 2 write"); end
        #2 rst_ni = 1'b0;
        #1;
        vectors++;
        if ({bus.we_o, bus.wlast_o, bus.waddr_o, bus.wrowaddr_o, bus.wdata_o, bus.re_o, bus.raddr_o, bus.rrowaddr_o} !== '0) begin
            miscompares++;
            $display("FAIL async_reset_ports: got we=%b wdata=%h re=%b, want all 0", bus.we_o, bus.wdata_o, bus.re_o);
        end
        vectors++;
        if ({bus.busy_o, bus.id_o, bus.finished_o, bus.finished_instr_id_o} !== '0) begin
            miscompares++;
            $display("FAIL async_reset_status: got busy=%b id=%0d fin=%b, want all 0", bus.busy_o, bus.id_o, bus.finished_o);
        end
        wq.delete();
        fq.delete();
        rd_stall = 0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        vectors++;
        if ({bus.finished_o, bus.busy_o, bus.we_o, bus.re_o, bus.id_o} !== '0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got fin=%b busy=%b we=%b re=%b id=%0d, want all 0",
                     bus.finished_o, bus.busy_o, bus.we_o, bus.re_o, bus.id_o);
        end
        issue(2'd0, 3'd0, 3'd0, 32'h0, 2'd0, 4'd15);
        wait_drain(ok);
        vectors++;
        if ({ok, bus.id_o} !== {1'b1, 4'd15}) begin
            miscompares++;
            $display("FAIL post_reset_instr: got drained=%b id=%0d, want drained=1 id=15", ok, bus.id_o);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        hold_ack = 1'b0; wready_rand = 1'b0; rd_stall = 0; rd_grants = 0;
        rst_ni = 1'b0;
        bus.start_i = 1'b0; bus.op_i = '0; bus.operand_reg_i = '0; bus.src_reg_i = '0;
        bus.scalar_i = '0; bus.sew_i = '0; bus.instr_id_i = '0;
        for (int r = 0; r < N_REGS; r++)
            for (int w = 0; w < N_ROWS; w++)
                rf[r][w] = {(RLEN / 32){16'(r), 16'(w)}};
        test_reset();
        test_zero();
        test_fill();
        test_fill_wready_random();
        test_move();
        test_back_to_back();
        test_finish_stall();
        test_reset_mid_move();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
